sram22_access_arbiter: RTL and testbench

- Two-requester access controller for a single-port SRAM22 macro: 2048 words x 32 bits, byte write mask, 1-cycle registered read.
- Arbitrates port 0 (BIST/debug) and port 1 (system) onto the macro pins.
- Tracks the one in-flight access; returns read data through a valid/ready response channel.
- Includes a hold register, because macro dout changes on every clock edge.

---
 rtl/sram22_access_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram22_access_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_access_arbiter.sv
// Two-requester arbiter for a single-port SRAM22 macro with a one-deep response slot and dout hold register.
// Define SRAM22_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with port 0 highest.
module sram22_access_arbiter #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_we,
    input  logic [WMASK_WIDTH-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    input  logic [DATA_WIDTH-1:0]  req0_wdata,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_we,
    input  logic [WMASK_WIDTH-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    input  logic [DATA_WIDTH-1:0]  req1_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_port,
    output logic                   rsp_we,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    logic                  pending_q, pending_d;
    logic                  fresh_q, fresh_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                   slot_free;
    logic                   grant0, grant1;
    logic                   accept;
    logic                   sel_port;
    logic                   sel_we;
    logic [WMASK_WIDTH-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    // The slot frees in the same cycle the current response is taken.
    assign slot_free = !pending_q | rsp_ready;

`ifdef SRAM22_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // last_q names the port granted most recently; the other port wins a conflict.
    assign grant0 = req0_valid & (!req1_valid | last_q);
    assign grant1 = req1_valid & (!req0_valid | !last_q);
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & !req0_valid;
`endif

    // Gating with rst_n keeps the macro free of writes while reset is held.
    assign req0_ready = rst_n & slot_free & grant0;
    assign req1_ready = rst_n & slot_free & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign sel_port  = !grant0;
    assign sel_we    = grant0 ? req0_we    : req1_we;
    assign sel_wmask = grant0 ? req0_wmask : req1_wmask;
    assign sel_addr  = grant0 ? req0_addr  : req1_addr;
    assign sel_wdata = grant0 ? req0_wdata : req1_wdata;

    // Idle cycles re-read the last address so the macro never sees a spurious write.
    assign sram_we    = accept & sel_we;
    assign sram_wmask = (accept & sel_we) ? sel_wmask : '0;
    assign sram_addr  = accept ? sel_addr : addr_q;
    assign sram_din   = accept ? sel_wdata : '0;

    assign rsp_valid = pending_q;
    assign rsp_port  = port_q;
    assign rsp_we    = we_q;
    // Macro dout is only meaningful in the cycle after a read issue; writes leave it undefined.
    assign rsp_rdata = fresh_q ? (we_q ? '0 : sram_dout) : hold_q;

    always_comb begin
        // NOTE: every next-state signal gets its default first so no path can infer a latch.
        pending_d = pending_q;
        fresh_d   = fresh_q;
        port_d    = port_q;
        we_d      = we_q;
        hold_d    = hold_q;
        addr_d    = addr_q;
`ifdef SRAM22_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        if (accept) begin
            pending_d = 1'b1;
            fresh_d   = 1'b1;
            port_d    = sel_port;
            we_d      = sel_we;
            addr_d    = sel_addr;
`ifdef SRAM22_ARB_ROUND_ROBIN_EN
            last_d    = sel_port;
`endif
        end else if (pending_q & rsp_ready) begin
            pending_d = 1'b0;
            fresh_d   = 1'b0;
        end else if (fresh_q) begin
            // Response stalled: capture dout before the next edge overwrites it.
            fresh_d = 1'b0;
            hold_d  = we_q ? '0 : sram_dout;
        end
    end

    // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            fresh_q   <= 1'b0;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            hold_q    <= '0;
            addr_q    <= '0;
`ifdef SRAM22_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            pending_q <= pending_d;
            fresh_q   <= fresh_d;
            port_q    <= port_d;
            we_q      <= we_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
`ifdef SRAM22_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram22_access_arbiter.sv
// Scoreboard bench for sram22_access_arbiter with a behavioural SRAM22 macro and a shadow memory.
module tb_sram22_access_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int MW = 4;

    typedef struct packed {
        logic          port;
        logic          we;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_we;
    logic [MW-1:0] req0_wmask;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [MW-1:0] req1_wmask;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp_valid, rsp_ready, rsp_port, rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    int vectors     = 0;
    int miscompares = 0;

    exp_t          sb_q[$];
    bit            port_log[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] dout_q;
    logic [DW-1:0] last_rdata;
    int            rsp_count;
    logic          bd_en;
    logic [DW-1:0] bd_data;

    always #5 clk = ~clk;

    sram22_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Macro model: masked write at the edge, registered read, dout undefined after a write.
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < MW; b++)
                if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            dout_q <= 'x;
        end else begin
            dout_q <= mem[sram_addr];
        end
        if (bd_en) mem[11'h7FF] <= bd_data;
    end
    assign sram_dout = dout_q;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 'h7FF) return 32'hA5A5A5A5;
        return (32'(i) * 32'h9E3779B1) ^ 32'h0F0F0F0F;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                            input logic [MW-1:0] mask);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (mask[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
        exp_t e;
        e.port  = port;
        e.we    = we;
        e.rdata = we ? '0 : shadow[addr];
        sb_q.push_back(e);
        if (we) shadow[addr] = merge(shadow[addr], wdata, wmask);
    endtask

    // Scoreboard: retire the oldest expectation on each handshake, then record new accepts.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rsp_port", 64'(rsp_port), 64'(e.port));
                    check("rsp_we", 64'(rsp_we), 64'(e.we));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
                last_rdata = rsp_rdata;
                port_log.push_back(rsp_port);
                rsp_count++;
            end
            if (req0_valid && req0_ready) sb_push(1'b0, req0_we, req0_addr, req0_wdata, req0_wmask);
            if (req1_valid && req1_ready) sb_push(1'b1, req1_we, req1_addr, req1_wdata, req1_wmask);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [MW-1:0] wmask, input string tag);
        if (port == 1'b0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata; req0_wmask = wmask;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata; req1_wmask = wmask;
        end
        @(negedge clk);
        check(tag, 64'(port ? req1_ready : req0_ready), 64'd1);
        tick();
        if (port == 1'b0) req0_valid = 1'b0;
        else              req1_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        tick();
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_p0;
        rst_n = 1'b0; rsp_ready = 1'b0; bd_en = 1'b0; bd_data = '0;
        rsp_count = 0; last_rdata = '0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_wmask = 4'hF; req0_addr = 11'h001; req0_wdata = '1;
        req1_valid = 1'b0; req1_we = 1'b0; req1_wmask = '0; req1_addr = '0; req1_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end

        // Reset state, with a write request held to prove ready and the macro stay quiet.
        @(negedge clk); @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_port", 64'(rsp_port), 64'd0);
        check("rst_rsp_we", 64'(rsp_we), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_req0_ready", 64'(req0_ready), 64'd0);
        check("rst_sram_we", 64'(sram_we), 64'd0);
        check("rst_sram_wmask", 64'(sram_wmask), 64'd0);
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        tick();

        // Full write then back-to-back read of the same word.
        issue(1'b1, 1'b1, 11'h005, 32'hDEADBEEF, 4'hF, "t1_wr_ready");
        issue(1'b1, 1'b0, 11'h005, '0, '0, "t1_rd_ready");
        tick();
        check("t1_raw_data", 64'(last_rdata), 64'h00000000DEADBEEF);

        // Partial write on lanes 0 and 2.
        issue(1'b1, 1'b1, 11'h005, 32'h11223344, 4'h5, "t2_wr_ready");
        issue(1'b1, 1'b0, 11'h005, '0, '0, "t2_rd_ready");
        tick();
        check("t2_partial_data", 64'(last_rdata), 64'h00000000DE22BE44);
        drain();

        // Contention: both ports request every cycle.
        port_log.delete();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 11'h010;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 11'h020;
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM22_ARB_ROUND_ROBIN_EN
            exp_p0 = (k % 2 == 0);
`else
            exp_p0 = 1'b1;
`endif
            @(negedge clk);
            check("cont_ready0", 64'(req0_ready), 64'(exp_p0));
            check("cont_ready1", 64'(req1_ready), 64'(!exp_p0));
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("cont_rsp_count", 64'(port_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < port_log.size(); k++) begin
`ifdef SRAM22_ARB_ROUND_ROBIN_EN
            check("cont_rsp_port", 64'(port_log[k]), 64'(k % 2));
`else
            check("cont_rsp_port", 64'(port_log[k]), 64'd0);
`endif
        end
        drain();

        // Backpressure: stalled read of 0x7FF while the macro word keeps changing underneath.
        rsp_ready = 1'b0;
        issue(1'b1, 1'b0, 11'h7FF, '0, '0, "bp_rd_ready");
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 11'h003;
        for (int k = 0; k < 5; k++) begin
            bd_en = 1'b1; bd_data = 32'h5000_0000 + 32'(k);
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rdata_stable", 64'(rsp_rdata), 64'h00000000A5A5A5A5);
            check("bp_req0_blocked", 64'(req0_ready), 64'd0);
            check("bp_req1_blocked", 64'(req1_ready), 64'd0);
            tick();
        end
        bd_data = 32'hA5A5A5A5;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_accept", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0; bd_en = 1'b0;
        drain();

        // Reset while a read response is still pending.
        rsp_ready = 1'b0;
        issue(1'b1, 1'b0, 11'h00A, '0, '0, "mr_rd_ready");
        rst_n = 1'b0;
        #1;
        check("mr_rsp_dropped", 64'(rsp_valid), 64'd0);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 11'h00A; req0_wdata = '1; req0_wmask = 4'hF;
        @(negedge clk);
        check("mr_no_sram_we", 64'(sram_we), 64'd0);
        check("mr_no_wmask", 64'(sram_wmask), 64'd0);
        check("mr_no_ready", 64'(req0_ready), 64'd0);
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mr_no_late_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        issue(1'b0, 1'b0, 11'h00A, '0, '0, "mr_post_ready");
        tick();
        check("mr_post_data", 64'(last_rdata), 64'(init_word('h00A)));
        drain();

        // Full throughput: 16 back-to-back reads with no bubbles.
        rsp_count = 0;
        for (int i = 0; i < 16; i++) begin
            req0_valid = 1'b1; req0_we = 1'b0; req0_addr = AW'(i);
            @(negedge clk);
            check("tp_ready", 64'(req0_ready), 64'd1);
            if (i > 0) check("tp_no_bubble", 64'(rsp_valid), 64'd1);
            tick();
        end
        req0_valid = 1'b0;
        @(negedge clk);
        check("tp_last_rsp", 64'(rsp_valid), 64'd1);
        tick();
        check("tp_rsp_count", 64'(rsp_count), 64'd16);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
